// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions used by the device model and the controller.
// Holds the {ras_n,cas_n,we_n} command encodings, the err_flags bit
// positions, the bank state type and the pin-level command decoder.
package sdram_pkg;

  localparam logic [2:0] CMD_LOAD_MODE = 3'b000;
  localparam logic [2:0] CMD_AREFR     = 3'b001;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] CMD_ACTIVE    = 3'b011;
  localparam logic [2:0] CMD_WRITE     = 3'b100;
  localparam logic [2:0] CMD_READ      = 3'b101;
  localparam logic [2:0] CMD_NOP       = 3'b111;

  localparam int ERR_IDLE_ACCESS = 0;
  localparam int ERR_DOUBLE_ACT  = 1;
  localparam int ERR_REFR_ACTIVE = 2;
  localparam int ERR_MODE        = 3;

  localparam int NUM_BANKS = 4;
  localparam int ROW_W     = 13;
  localparam int WORD_W    = 16;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_e;

  // A deselected chip or a low clock-enable is indistinguishable from NOP.
  function automatic logic [2:0] decode_cmd(input logic cs_n, input logic cke,
                                            input logic ras_n, input logic cas_n,
                                            input logic we_n);
    if (cs_n || !cke) return CMD_NOP;
    return {ras_n, cas_n, we_n};
  endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// Read-latency pipeline for the SDRAM device model.
// Three-deep shift register of {valid, data}; the output tap is chosen by
// the programmed CAS latency (1 -> first stage, 3 -> last stage, 0 -> none).
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset (valids only)
//   flush              drop everything in flight (bus turnaround on WRITE)
//   in_vld, in_data    word fetched on the READ command edge
//   cas_lat            selects the output tap
//   out_vld, out_data  word to put on the bus this cycle
module sdram_rd_pipe #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        cas_lat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  logic              vld_p0, vld_p1, vld_p2;
  logic [DATA_W-1:0] data_p0, data_p1, data_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= in_vld;
      vld_p1 <= flush ? 1'b0 : vld_p0;
      vld_p2 <= flush ? 1'b0 : vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    data_p0 <= in_data;
    data_p1 <= data_p0;
    data_p2 <= data_p1;
  end

  always_comb begin
    out_vld  = 1'b0;
    out_data = data_p0;
    case (cas_lat)
      2'd1: begin out_vld = vld_p0; out_data = data_p0; end
      2'd2: begin out_vld = vld_p1; out_data = data_p1; end
      2'd3: begin out_vld = vld_p2; out_data = data_p2; end
      default: out_vld = 1'b0;
    endcase
  end

endmodule

// File: rtl/sdram_device_model.sv
// Behavioural-but-synthesizable SDRAM device model for controller testing.
// Decodes SDRAM commands, tracks per-bank open rows, stores 2^MEM_AW words,
// returns read data after the programmed CAS latency and records protocol
// violations in sticky flags. No inter-command timing is enforced.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   dr_cs_n/ras_n/cas_n/we_n/cke    command pins
//   dr_ba, dr_a                     bank and row/column/mode address
//   dr_dqml, dr_dqmh                byte masks (low = byte enabled)
//   dr_dq                           bidirectional data bus
//   err_flags                       sticky violation flags
//   refr_cnt                        saturating AUTO REFRESH count
//   cas_lat                         programmed CAS latency (0 = unset)
module sdram_device_model
  import sdram_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dr_cs_n,
  input  logic        dr_ras_n,
  input  logic        dr_cas_n,
  input  logic        dr_we_n,
  input  logic        dr_cke,
  input  logic [1:0]  dr_ba,
  input  logic [12:0] dr_a,
  input  logic        dr_dqml,
  input  logic        dr_dqmh,
  inout  wire  [15:0] dr_dq,
  output logic [3:0]  err_flags,
  output logic [15:0] refr_cnt,
  output logic [1:0]  cas_lat
);

  localparam int COL_W = MEM_AW - 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [WORD_W-1:0] mem [2**MEM_AW];
  bank_state_e       bank_st  [NUM_BANKS];
  logic [ROW_W-1:0]  bank_row [NUM_BANKS];

  logic [2:0]        cmd;
  logic              mode_ok;
  logic              bank_open;
  logic              any_active;
  logic              rd_fire;
  logic              wr_fire;
  logic              bus_turn;
  logic [MEM_AW-1:0] mem_idx;
  logic              pipe_vld;
  logic [WORD_W-1:0] pipe_data;
  logic              drv_en;
  logic              unused_row_bits;

  assign cmd       = decode_cmd(dr_cs_n, dr_cke, dr_ras_n, dr_cas_n, dr_we_n);
  assign mode_ok   = (cas_lat != 2'd0);
  assign bank_open = (bank_st[dr_ba] == BANK_ACTIVE);
  assign rd_fire   = (cmd == CMD_READ)  && mode_ok && bank_open;
  assign wr_fire   = (cmd == CMD_WRITE) && mode_ok && bank_open;
  assign bus_turn  = (cmd == CMD_WRITE);
  assign mem_idx   = {dr_ba, bank_row[dr_ba][1:0], dr_a[COL_W-1:0]};

  // Only the low two row bits select storage; the rest are kept for fidelity.
  assign unused_row_bits = ^{bank_row[0][ROW_W-1:2], bank_row[1][ROW_W-1:2],
                             bank_row[2][ROW_W-1:2], bank_row[3][ROW_W-1:2]};

  always_comb begin
    any_active = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (bank_st[i] == BANK_ACTIVE) any_active = 1'b1;
  end

  // Command edge: bank state, mode register, refresh count and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) bank_st[i] <= BANK_IDLE;
      cas_lat   <= 2'd0;
      err_flags <= 4'd0;
      refr_cnt  <= 16'd0;
    end else begin
      case (cmd)
        CMD_ACTIVE: begin
          if (!mode_ok)       err_flags[ERR_MODE]       <= 1'b1;
          else if (bank_open) err_flags[ERR_DOUBLE_ACT] <= 1'b1;
          else                bank_st[dr_ba]            <= BANK_ACTIVE;
        end
        CMD_READ, CMD_WRITE: begin
          if (!mode_ok)        err_flags[ERR_MODE]        <= 1'b1;
          else if (!bank_open) err_flags[ERR_IDLE_ACCESS] <= 1'b1;
          else if (dr_a[10])   bank_st[dr_ba]             <= BANK_IDLE;
        end
        CMD_PRECHARGE: begin
          if (dr_a[10]) for (int i = 0; i < NUM_BANKS; i++) bank_st[i] <= BANK_IDLE;
          else          bank_st[dr_ba] <= BANK_IDLE;
        end
        CMD_AREFR: begin
          refr_cnt <= sat_inc16(refr_cnt);
          if (any_active) err_flags[ERR_REFR_ACTIVE] <= 1'b1;
        end
        CMD_LOAD_MODE: begin
          if (dr_a[6:4] == 3'd1 || dr_a[6:4] == 3'd2 || dr_a[6:4] == 3'd3)
            cas_lat <= dr_a[5:4];
          else
            err_flags[ERR_MODE] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Command edge: storage write and open-row capture (data, never reset)
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (!dr_dqml) mem[mem_idx][7:0]  <= dr_dq[7:0];
      if (!dr_dqmh) mem[mem_idx][15:8] <= dr_dq[15:8];
    end
    if (cmd == CMD_ACTIVE && mode_ok && !bank_open)
      bank_row[dr_ba] <= dr_a;
  end

  sdram_rd_pipe #(
    .DATA_W (WORD_W)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus_turn),
    .in_vld   (rd_fire),
    .in_data  (mem[mem_idx]),
    .cas_lat  (cas_lat),
    .out_vld  (pipe_vld),
    .out_data (pipe_data)
  );

  // rst_n in the enable releases the bus the instant reset asserts; a WRITE
  // on the pins means the controller owns the bus this cycle.
  assign drv_en = rst_n && pipe_vld && !bus_turn;
  assign dr_dq  = drv_en ? pipe_data : {WORD_W{1'bz}};

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model. Read commands push the expected
// word and the cycle it must appear into a queue; a monitor pops an entry
// whenever the model drives the bus.
module tb_sdram_device_model;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, cke = 1'b1;
  logic [1:0]  ba = 2'd0;
  logic [12:0] a = 13'd0;
  logic        dqml = 1'b0, dqmh = 1'b0;
  logic [15:0] dq_drv = 16'd0;
  logic        dq_oe = 1'b0;
  wire  [15:0] dr_dq;
  logic [3:0]  err_flags;
  logic [15:0] refr_cnt;
  logic [1:0]  cas_lat;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int cl = 0;

  assign dr_dq = dq_oe ? dq_drv : 16'bz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_device_model #(.MEM_AW(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dr_cs_n   (cs_n),
    .dr_ras_n  (ras_n),
    .dr_cas_n  (cas_n),
    .dr_we_n   (we_n),
    .dr_cke    (cke),
    .dr_ba     (ba),
    .dr_a      (a),
    .dr_dqml   (dqml),
    .dr_dqmh   (dqmh),
    .dr_dq     (dr_dq),
    .err_flags (err_flags),
    .refr_cnt  (refr_cnt),
    .cas_lat   (cas_lat)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Present one command for exactly one rising edge, then return to NOP.
  task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                       input logic [15:0] d, input logic oe, input logic mh,
                       input logic exp_en, input logic [15:0] exp_d);
    @(negedge clk);
    #1;
    cs_n = 1'b0; {ras_n, cas_n, we_n} = c; ba = b; a = addr;
    dq_drv = d; dq_oe = oe; dqmh = mh;
    if (exp_en) exp_q.push_back('{data: exp_d, cyc: cyc + cl});
    @(posedge clk);
    #1;
    cs_n = 1'b1; {ras_n, cas_n, we_n} = CMD_NOP; dq_oe = 1'b0; dqmh = 1'b0;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr);
    drive(c, b, addr, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic wr(input logic [1:0] b, input logic [12:0] addr, input logic [15:0] d,
                    input logic mh);
    drive(CMD_WRITE, b, addr, d, 1'b1, mh, 1'b0, 16'd0);
  endtask

  task automatic rd(input logic [1:0] b, input logic [12:0] addr, input logic [15:0] d);
    drive(CMD_READ, b, addr, 16'd0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic rd_silent(input logic [1:0] b, input logic [12:0] addr);
    drive(CMD_READ, b, addr, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any driven bus must match the oldest expected read.
  always @(negedge clk) begin
    if (dr_dq !== 16'bz) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_drive: got %h at cycle %0d expected high-Z", dr_dq, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_data", {16'd0, dr_dq}, {16'd0, e.data});
        check("rd_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_err", {28'd0, err_flags}, 32'h0);
    check("rst_refr", {16'd0, refr_cnt}, 32'h0);
    check("rst_cl", {30'd0, cas_lat}, 32'h0);
    check("rst_hiz", {31'd0, dr_dq === 16'bz}, 32'h1);
    #1 rst_n = 1'b1;

    // ACTIVE before any LOAD MODE
    cmd(CMD_ACTIVE, 2'd0, 13'd0);
    check("act_before_mode", {28'd0, err_flags}, 32'h8);
    rst_n = 1'b0;
    #1 check("err_cleared", {28'd0, err_flags}, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Init sequence
    cmd(CMD_PRECHARGE, 2'd0, 13'h400);
    cmd(CMD_AREFR, 2'd0, 13'd0);
    cmd(CMD_AREFR, 2'd0, 13'd0);
    cmd(CMD_LOAD_MODE, 2'd0, 13'h0220);
    cl = 2;
    check("init_cl", {30'd0, cas_lat}, 32'd2);
    check("init_refr", {16'd0, refr_cnt}, 32'd2);
    check("init_err", {28'd0, err_flags}, 32'h0);

    // Write with auto-precharge, reopen, read back at CL=2
    cmd(CMD_ACTIVE, 2'd1, 13'h0003);
    wr(2'd1, 13'h405, 16'hBEEF, 1'b0);
    cmd(CMD_ACTIVE, 2'd1, 13'h0003);
    rd(2'd1, 13'h005, 16'hBEEF);
    idle(4);
    check("hiz_after_read", {31'd0, dr_dq === 16'bz}, 32'h1);

    // Byte mask
    wr(2'd1, 13'h010, 16'h1234, 1'b0);
    wr(2'd1, 13'h010, 16'hABCD, 1'b1);
    rd(2'd1, 13'h010, 16'h12CD);
    idle(3);

    // Bus turnaround: the read is dropped, the write lands
    rd_silent(2'd1, 13'h005);
    wr(2'd1, 13'h011, 16'h5555, 1'b0);
    rd(2'd1, 13'h011, 16'h5555);
    idle(4);

    // Access to an idle bank, double ACTIVE
    cmd(CMD_PRECHARGE, 2'd0, 13'h400);
    rd_silent(2'd2, 13'h000);
    check("idle_read_err", {28'd0, err_flags}, 32'h1);
    idle(3);
    cmd(CMD_ACTIVE, 2'd0, 13'h0000);
    cmd(CMD_ACTIVE, 2'd0, 13'h0007);
    check("double_act_err", {28'd0, err_flags}, 32'h3);

    // Refresh with a bank open, invalid mode
    cmd(CMD_AREFR, 2'd0, 13'd0);
    check("refr_active_err", {28'd0, err_flags}, 32'h7);
    check("refr_cnt_3", {16'd0, refr_cnt}, 32'd3);
    cmd(CMD_LOAD_MODE, 2'd0, 13'h0000);
    check("bad_mode_err", {28'd0, err_flags}, 32'hF);
    check("bad_mode_cl", {30'd0, cas_lat}, 32'd2);

    // Rejected ACTIVE must not have changed bank 0's open row
    wr(2'd0, 13'h002, 16'h7777, 1'b0);
    cmd(CMD_PRECHARGE, 2'd0, 13'h400);
    cmd(CMD_ACTIVE, 2'd0, 13'h0000);
    rd(2'd0, 13'h002, 16'h7777);
    idle(4);

    // CL=3, back-to-back reads
    cmd(CMD_LOAD_MODE, 2'd0, 13'h0030);
    cl = 3;
    check("cl3", {30'd0, cas_lat}, 32'd3);
    wr(2'd0, 13'h000, 16'h1111, 1'b0);
    wr(2'd0, 13'h001, 16'h2222, 1'b0);
    rd(2'd0, 13'h000, 16'h1111);
    rd(2'd0, 13'h001, 16'h2222);
    idle(5);

    // Reset while read data is on the bus
    rd_silent(2'd0, 13'h000);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("drive_before_rst", {16'd0, dr_dq}, 32'h1111);
    rst_n = 1'b0;
    #1;
    check("rst_release_hiz", {31'd0, dr_dq === 16'bz}, 32'h1);
    check("rst2_cl", {30'd0, cas_lat}, 32'd0);
    check("rst2_err", {28'd0, err_flags}, 32'h0);
    check("rst2_refr", {16'd0, refr_cnt}, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Memory survives reset
    cmd(CMD_LOAD_MODE, 2'd0, 13'h0020);
    cl = 2;
    cmd(CMD_ACTIVE, 2'd1, 13'h0003);
    rd(2'd1, 13'h005, 16'hBEEF);
    idle(5);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_device_model.md
SDRAM_DEVICE_MODEL -- requirements
Module: sdram_device_model

Interface
REQ-001 Parameter MEM_AW, default 10, SHALL set the backing-store depth to 2^MEM_AW 16-bit words (MEM_AW >= 6).
REQ-002 clk  input  1  sole clock; all sampling on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 dr_cs_n, dr_ras_n, dr_cas_n, dr_we_n, dr_cke  input  1 each  SDRAM command pins.
REQ-005 dr_ba  input  2  bank address.
REQ-006 dr_a  input  13  row, column and mode address.
REQ-007 dr_dqml, dr_dqmh  input  1 each  byte masks (low = byte enabled).
REQ-008 dr_dq  inout  16  data bus; the model drives it only during read data cycles, otherwise high-Z.
REQ-009 err_flags  output  4  sticky protocol-violation flags.
REQ-010 refr_cnt  output  16  count of accepted AUTO REFRESH commands.
REQ-011 cas_lat  output  2  currently programmed CAS latency (0 = mode not loaded).

Function
REQ-012 The command SHALL be decoded as {ras_n,cas_n,we_n}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO REFRESH, 000 LOAD MODE; cs_n=1 or cke=0 SHALL be treated as NOP.
REQ-013 Per-bank state SHALL be IDLE or ACTIVE with a stored 13-bit open row; all banks are IDLE after reset.
REQ-014 ACTIVE SHALL move bank ba from IDLE to ACTIVE and store dr_a as the open row.
REQ-015 PRECHARGE SHALL idle bank ba, or all banks when a[10]=1; precharging an IDLE bank is legal and does nothing.
REQ-016 LOAD MODE SHALL latch CAS latency from a[6:4]; values 1, 2 and 3 are accepted, any other value sets err_flags[3] and leaves cas_lat unchanged.
REQ-017 Storage index SHALL be {ba, row[1:0], col[MEM_AW-5:0]}, where col is a[8:0] at the READ/WRITE command.
REQ-018 WRITE SHALL take data from dr_dq on the same edge and update byte [7:0] only if dqml=0 and byte [15:8] only if dqmh=0.
REQ-019 READ sampled at edge T SHALL drive the stored word from edge T+CL-1 until edge T+CL, so the controller samples it at edge T+CL; outside this window dr_dq is high-Z.
REQ-020 The read pipeline SHALL be a CL-deep shift register of {valid, data}, so back-to-back READs on consecutive cycles each return data.
REQ-021 READ or WRITE with a[10]=1 SHALL complete the access and then return the bank to IDLE (auto-precharge).
REQ-022 A WRITE issued while read data is pending SHALL be performed; the pending read output SHALL be suppressed (bus turnaround).
REQ-023 err_flags[0] SHALL set on READ/WRITE to an IDLE bank; the access is ignored and no data is driven.
REQ-024 err_flags[1] SHALL set on ACTIVE to an already ACTIVE bank; the open row is not changed.
REQ-025 err_flags[2] SHALL set on AUTO REFRESH while any bank is ACTIVE; refr_cnt still increments.
REQ-026 err_flags[3] SHALL also set on ACTIVE/READ/WRITE before any valid LOAD MODE; the command is ignored.
REQ-027 refr_cnt SHALL increment by 1 per AUTO REFRESH and saturate at 16'hFFFF.
REQ-028 The model SHALL impose no tRCD/tRP/tRFC timing checks, so any command spacing of 1 cycle or more is accepted.

Reset
REQ-029 While rst_n=0: all banks IDLE, cas_lat=0, err_flags=0, refr_cnt=0, read pipeline cleared, dr_dq high-Z; memory contents are not cleared.
REQ-030 Reset asserted mid-READ SHALL release dr_dq asynchronously in the same cycle.

Structure
REQ-031 Command encodings (CMD_*) and err_flags bit positions SHALL be localparams in a shared package sdram_pkg, used by both this block and the controller.
REQ-032 The read-latency shift register SHALL be a sub-module sdram_rd_pipe (depth 3, tap selected by cas_lat).

Verification
REQ-033 Init: PRECHARGE a10=1, 2x AREFR, LOAD MODE a=0x0220 -> cas_lat=2, refr_cnt=2, err_flags=0.
REQ-034 ACTIVE ba=1 row=0x0003; WRITE col=0x005 dq=0xBEEF a10=1; ACTIVE; READ col=0x005 at edge T -> dr_dq=0xBEEF sampled at edge T+2, high-Z at edge T+3.
REQ-035 Write 0x1234, then WRITE 0xABCD with dqmh=1 to the same address, then read -> 0x12CD.
REQ-036 READ to IDLE bank 2 -> err_flags=4'b0001 and dr_dq stays high-Z; ACTIVE twice to bank 0 -> err_flags[1]=1.
REQ-037 ACTIVE bank 0, then AREFR -> err_flags[2]=1 and refr_cnt increments; ACTIVE before any LOAD MODE after reset -> err_flags[3]=1.
REQ-038 Back-to-back READs at cols 0 and 1 with CL=3 -> consecutive data words on edges T+3 and T+4; rst_n low at T+1 -> dr_dq high-Z immediately.
